wb_fetch_seq: RTL

- Read-side sequencer for the weight/bias ROM bank (32 layer-1 lanes, 10 layer-2 lanes, registered reads with 1-cycle latency).
- Generates the ROM row counters ctr1/ctr2 and captures each returned row.
- Delivers rows as a valid/ready stream to the downstream MAC array: all layer-1 rows, then a hold until layer-2 is released, then all layer-2 rows.
- Full throughput of 1 row/cycle under backpressure, with no dropped or duplicated rows.

---
 rtl/wb_fetch_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/wb_fetch_seq.sv
// ---------------------------------------------------------------------------
// wb_fetch_seq
// Read-side sequencer for the weight/bias ROM bank. It walks the layer-1 row
// counter and then the layer-2 row counter, captures each row the ROM returns
// one cycle after the address was sampled, and delivers the rows through a
// 2-entry FIFO as a valid/ready stream. Layer-2 fetching waits until l2_go has
// been seen and the layer-1 rows have fully drained.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start, abort       run control (start when idle, synchronous abort)
//   l2_go              layer-2 release pulse, latched until used
//   ctr1, ctr2         ROM row addresses for layer 1 / layer 2
//   w1_flat, w2_flat   ROM row data (32 and 10 lanes of 32 bits)
//   out_valid/ready    output stream handshake
//   out_data           row data (layer 2 zero-extended from 320 bits)
//   out_layer/idx/last row tag: layer, row index, final row of the layer
//   busy, done         run in progress, one-cycle end-of-run pulse
// ---------------------------------------------------------------------------
module wb_fetch_seq #(
   parameter int unsigned L1_LEN = 785,
   parameter int unsigned L2_LEN = 33,
   parameter int unsigned CW     = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic          abort,
   input  logic          l2_go,
   output logic [CW-1:0] ctr1,
   output logic [CW-1:0] ctr2,
   input  logic [1023:0] w1_flat,
   input  logic [319:0]  w2_flat,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1023:0] out_data,
   output logic          out_layer,
   output logic [9:0]    out_idx,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StFetch1 = 3'd1;
   localparam logic [2:0] StHold   = 3'd2;
   localparam logic [2:0] StFetch2 = 3'd3;
   localparam logic [2:0] StDrain  = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] ctr1_q, ctr1_d, ctr2_q, ctr2_d;
   logic          latch_q, latch_d;
   logic          done_q, done_d;
   logic          inflight_q, inflight_d;
   // Tag layout: {layer, last, idx[9:0]}
   logic [11:0]   inf_tag_q, inf_tag_d;
   logic [1:0]    occ_q, occ_d;
   logic [1023:0] data0_q, data1_q;
   logic [11:0]   tag0_q, tag1_q;

   logic          pop, push, issue, credit_ok, fetching, last1, last2;
   logic [1023:0] row_data;

   assign out_valid = (occ_q != 2'd0);
   assign pop       = out_valid & out_ready;
   assign push      = inflight_q & ~abort;
   assign fetching  = (state_q == StFetch1) || (state_q == StFetch2);
   // occ + inflight - pop < 2, rearranged to avoid underflow
   assign credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
   assign issue     = credit_ok & fetching & ~abort;
   assign last1     = (ctr1_q == CW'(L1_LEN - 1));
   assign last2     = (ctr2_q == CW'(L2_LEN - 1));
   assign row_data  = inf_tag_q[11] ? {704'd0, w2_flat} : w1_flat;

   always_comb begin
      state_d    = state_q;
      ctr1_d     = ctr1_q;
      ctr2_d     = ctr2_q;
      latch_d    = latch_q;
      done_d     = 1'b0;
      inflight_d = issue;
      inf_tag_d  = inf_tag_q;
      if (abort) begin
         state_d = StIdle;
         latch_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d = StFetch1;
                  ctr1_d  = '0;
                  latch_d = l2_go;
               end
            end
            StFetch1: begin
               if (l2_go) latch_d = 1'b1;
               if (issue) begin
                  inf_tag_d = {1'b0, last1, ctr1_q[9:0]};
                  if (last1) state_d = StHold;
                  else       ctr1_d  = ctr1_q + 1'b1;
               end
            end
            StHold: begin
               if (l2_go) latch_d = 1'b1;
               if (occ_q == 2'd0 && !inflight_q && (l2_go || latch_q)) begin
                  state_d = StFetch2;
                  ctr2_d  = '0;
                  latch_d = 1'b0;
               end
            end
            StFetch2: begin
               if (issue) begin
                  inf_tag_d = {1'b1, last2, ctr2_q[9:0]};
                  if (last2) state_d = StDrain;
                  else       ctr2_d  = ctr2_q + 1'b1;
               end
            end
            StDrain: begin
               if (pop && out_last && out_layer) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      occ_d = occ_q;
      if (abort) occ_d = 2'd0;
      else       occ_d = occ_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         ctr1_q     <= '0;
         ctr2_q     <= '0;
         latch_q    <= 1'b0;
         done_q     <= 1'b0;
         inflight_q <= 1'b0;
         inf_tag_q  <= '0;
         occ_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         ctr1_q     <= ctr1_d;
         ctr2_q     <= ctr2_d;
         latch_q    <= latch_d;
         done_q     <= done_d;
         inflight_q <= inflight_d;
         inf_tag_q  <= inf_tag_d;
         occ_q      <= occ_d;
      end
   end

   // Slot 0 is the head. A pop shifts slot 1 down; a push lands in the first
   // free slot after that pop (the later assignment wins when both hit slot 0).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data0_q <= '0;
         data1_q <= '0;
         tag0_q  <= '0;
         tag1_q  <= '0;
      end else begin
         if (pop) begin
            data0_q <= data1_q;
            tag0_q  <= tag1_q;
         end
         if (push) begin
            if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) begin
               data0_q <= row_data;
               tag0_q  <= inf_tag_q;
            end else begin
               data1_q <= row_data;
               tag1_q  <= inf_tag_q;
            end
         end
      end
   end

   assign ctr1      = ctr1_q;
   assign ctr2      = ctr2_q;
   assign out_data  = data0_q;
   assign out_layer = tag0_q[11];
   assign out_last  = tag0_q[10];
   assign out_idx   = tag0_q[9:0];
   assign busy      = (state_q != StIdle);
   assign done      = done_q;

endmodule
